pll_lock_monitor: RTL and testbench

Closed-loop supervisor for the LCD PLL. It drives the PLL reset input and measures a divided PLL output clock against refclk. It declares lock once the frequency is in tolerance for several consecutive windows, and re-resets the PLL on loss of lock or persistent frequency error. It sits in the refclk domain beside the PLL and gates the downstream 8080-to-RGB logic through `locked`.

---
 rtl/pll_mon_pkg.sv | 18 +
 rtl/pll_mon_sync.sv | 40 ++++
 rtl/pll_lock_monitor.sv | 228 ++++++++++++++++++++++
 tb/tb_pll_lock_monitor.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pll_mon_pkg.sv
// ---------------------------------------------------------------------------
// pll_mon_pkg
// Shared definitions for the LCD PLL lock monitor: the supervisor state
// encoding and the default width of the edge/window counters.
// ---------------------------------------------------------------------------
package pll_mon_pkg;

   localparam int CNT_W_DEF = 16;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RESET_PLL = 3'd1,
      SETTLE    = 3'd2,
      MEASURE   = 3'd3,
      LOCKED    = 3'd4
   } pll_mon_state_t;

endpackage

// File: rtl/pll_mon_sync.sv
// ---------------------------------------------------------------------------
// pll_mon_sync
// Two-flop synchroniser for an asynchronous level, plus a third stage used
// to flag the rising edge of the synchronised level.
// Ports:
//   clk     in  sampling clock (refclk)
//   rst_n   in  asynchronous active-low reset
//   i_async in  asynchronous input
//   o_sync  out synchronised level (2 flops after i_async)
//   o_rise  out one-cycle pulse on a rising edge of o_sync
// ---------------------------------------------------------------------------
module pll_mon_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic i_async,
   output logic o_sync,
   output logic o_rise
);

   logic r_meta;
   logic r_sync;
   logic r_dly;

   // Synchroniser chain followed by the edge-compare stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_dly  <= 1'b0;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
         r_dly  <= r_sync;
      end
   end

   assign o_sync = r_sync;
   assign o_rise = r_sync & ~r_dly;

endmodule

// File: rtl/pll_lock_monitor.sv
// ---------------------------------------------------------------------------
// pll_lock_monitor
// Closed-loop supervisor for the LCD PLL. Holds the PLL in reset, releases
// it, lets it settle, then counts edges of a divided PLL toggle over fixed
// refclk windows. Declares lock after LOCK_WINDOWS consecutive in-tolerance
// windows; re-resets the PLL after MAX_MISS bad windows, or on any bad
// window / lock-flag drop while locked.
// Ports:
//   refclk       in  24 MHz reference, the only clock
//   reset_n      in  asynchronous active-low reset
//   enable       in  run the monitor; low forces IDLE
//   meas_tog     in  asynchronous divided PLL toggle
//   pll_lock_in  in  asynchronous PLL lock flag
//   pll_reset    out active-high PLL reset
//   locked       out frequency verified and lock flag high
//   freq_count   out edge count of the last completed window
//   count_valid  out one-cycle pulse when freq_count updates
//   relock_count out saturating count of PLL re-reset events
// ---------------------------------------------------------------------------
module pll_lock_monitor
   import pll_mon_pkg::*;
#(
   parameter int REF_WINDOW    = 24000,
   parameter int EXP_COUNT     = 2250,
   parameter int TOL           = 4,
   parameter int LOCK_WINDOWS  = 4,
   parameter int MAX_MISS      = 8,
   parameter int RST_CYCLES    = 240,
   parameter int SETTLE_CYCLES = 2400,
   parameter int CNT_W         = CNT_W_DEF
) (
   input  logic             refclk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             meas_tog,
   input  logic             pll_lock_in,
   output logic             pll_reset,
   output logic             locked,
   output logic [CNT_W-1:0] freq_count,
   output logic             count_valid,
   output logic [7:0]       relock_count
);

   pll_mon_state_t r_state, w_state_nxt;

   logic [CNT_W-1:0] r_tmr, w_tmr_nxt;
   logic [CNT_W-1:0] r_win, w_win_nxt;
   logic [CNT_W-1:0] r_edge, w_edge_nxt;
   logic [CNT_W-1:0] r_freq, w_freq_nxt;
   logic [7:0]       r_good, w_good_nxt;
   logic [7:0]       r_miss, w_miss_nxt;
   logic [7:0]       r_relock, w_relock_nxt;
   logic             r_locked, w_locked_nxt;
   logic             r_cv, w_cv_nxt;
   logic             r_pll_reset;
   logic             w_do_relock;

   logic             w_rise;
   logic             w_lock;
   logic [CNT_W-1:0] w_edge_inc;
   logic [CNT_W:0]   w_freq_ext;
   logic [CNT_W:0]   w_exp_ext;
   logic [CNT_W:0]   w_diff;
   logic             w_good_win;
   logic             w_window_end;

   pll_mon_sync u_sync_tog (
      .clk     (refclk),
      .rst_n   (reset_n),
      .i_async (meas_tog),
      .o_sync  (),
      .o_rise  (w_rise)
   );

   pll_mon_sync u_sync_lock (
      .clk     (refclk),
      .rst_n   (reset_n),
      .i_async (pll_lock_in),
      .o_sync  (w_lock),
      .o_rise  ()
   );

   // Edge count including this cycle's edge, saturating at all-ones.
   assign w_edge_inc = (w_rise && (r_edge != {CNT_W{1'b1}})) ? (r_edge + CNT_W'(1)) : r_edge;

   // Tolerance check one bit wider so the subtraction can never wrap.
   assign w_freq_ext   = {1'b0, w_edge_inc};
   assign w_exp_ext    = (CNT_W+1)'(EXP_COUNT);
   assign w_diff       = (w_freq_ext >= w_exp_ext) ? (w_freq_ext - w_exp_ext) : (w_exp_ext - w_freq_ext);
   assign w_good_win   = (w_diff <= (CNT_W+1)'(TOL)) && w_lock;
   assign w_window_end = (r_win == CNT_W'(REF_WINDOW - 1));

   // Next-state and datapath decode; enable low beats lock drop beats window evaluation.
   always_comb begin
      w_state_nxt  = r_state;
      w_tmr_nxt    = r_tmr;
      w_win_nxt    = r_win;
      w_edge_nxt   = r_edge;
      w_freq_nxt   = r_freq;
      w_good_nxt   = r_good;
      w_miss_nxt   = r_miss;
      w_locked_nxt = r_locked;
      w_relock_nxt = r_relock;
      w_cv_nxt     = 1'b0;
      w_do_relock  = 1'b0;

      if (!enable) begin
         w_state_nxt  = IDLE;
         w_tmr_nxt    = '0;
         w_win_nxt    = '0;
         w_edge_nxt   = '0;
         w_good_nxt   = 8'd0;
         w_miss_nxt   = 8'd0;
         w_locked_nxt = 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               w_state_nxt = RESET_PLL;
               w_tmr_nxt   = '0;
            end
            RESET_PLL: begin
               if (r_tmr == CNT_W'(RST_CYCLES - 1)) begin
                  w_state_nxt = SETTLE;
                  w_tmr_nxt   = '0;
               end else begin
                  w_tmr_nxt = r_tmr + CNT_W'(1);
               end
            end
            SETTLE: begin
               if (r_tmr == CNT_W'(SETTLE_CYCLES - 1)) begin
                  w_state_nxt = MEASURE;
                  w_tmr_nxt   = '0;
                  w_win_nxt   = '0;
                  w_edge_nxt  = '0;
                  w_good_nxt  = 8'd0;
                  w_miss_nxt  = 8'd0;
               end else begin
                  w_tmr_nxt = r_tmr + CNT_W'(1);
               end
            end
            MEASURE, LOCKED: begin
               if ((r_state == LOCKED) && !w_lock) begin
                  // Partial window is dropped: no freq_count update.
                  w_do_relock = 1'b1;
               end else if (w_window_end) begin
                  // Next window starts from zero; its first-cycle edge is added next cycle.
                  w_win_nxt  = '0;
                  w_edge_nxt = '0;
                  w_freq_nxt = w_edge_inc;
                  w_cv_nxt   = 1'b1;
                  if (w_good_win) begin
                     w_miss_nxt = 8'd0;
                     if ((r_state == MEASURE) && (r_good == 8'(LOCK_WINDOWS - 1))) begin
                        w_state_nxt  = LOCKED;
                        w_locked_nxt = 1'b1;
                        w_good_nxt   = 8'd0;
                     end else if (r_state == MEASURE) begin
                        w_good_nxt = r_good + 8'd1;
                     end else begin
                        w_good_nxt = 8'd0;
                     end
                  end else if ((r_state == LOCKED) || (r_miss == 8'(MAX_MISS - 1))) begin
                     w_do_relock = 1'b1;
                  end else begin
                     w_good_nxt = 8'd0;
                     w_miss_nxt = r_miss + 8'd1;
                  end
               end else begin
                  w_win_nxt  = r_win + CNT_W'(1);
                  w_edge_nxt = w_edge_inc;
               end
            end
            default: begin
               w_state_nxt = IDLE;
            end
         endcase

         if (w_do_relock) begin
            w_state_nxt  = RESET_PLL;
            w_tmr_nxt    = '0;
            w_win_nxt    = '0;
            w_edge_nxt   = '0;
            w_good_nxt   = 8'd0;
            w_miss_nxt   = 8'd0;
            w_locked_nxt = 1'b0;
            w_relock_nxt = (r_relock == 8'hFF) ? r_relock : (r_relock + 8'd1);
         end else begin
            w_relock_nxt = r_relock;
         end
      end
   end

   // State and datapath registers; pll_reset is decoded from the next state.
   always_ff @(posedge refclk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_tmr       <= '0;
         r_win       <= '0;
         r_edge      <= '0;
         r_freq      <= '0;
         r_good      <= 8'd0;
         r_miss      <= 8'd0;
         r_relock    <= 8'd0;
         r_locked    <= 1'b0;
         r_cv        <= 1'b0;
         r_pll_reset <= 1'b1;
      end else begin
         r_state     <= w_state_nxt;
         r_tmr       <= w_tmr_nxt;
         r_win       <= w_win_nxt;
         r_edge      <= w_edge_nxt;
         r_freq      <= w_freq_nxt;
         r_good      <= w_good_nxt;
         r_miss      <= w_miss_nxt;
         r_relock    <= w_relock_nxt;
         r_locked    <= w_locked_nxt;
         r_cv        <= w_cv_nxt;
         r_pll_reset <= (w_state_nxt == IDLE) || (w_state_nxt == RESET_PLL);
      end
   end

   assign pll_reset    = r_pll_reset;
   assign locked       = r_locked;
   assign freq_count   = r_freq;
   assign count_valid  = r_cv;
   assign relock_count = r_relock;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// ---------------------------------------------------------------------------
// tb_pll_lock_monitor
// Directed bench for pll_lock_monitor with shrunk timing parameters.
// meas_tog is produced either as a free-running period-5 wave (exactly 20
// rising edges in any 100-cycle window) or as bursts of N pulses launched
// at the start of a window, spaced 3 cycles apart.
// ---------------------------------------------------------------------------
module tb_pll_lock_monitor;

   localparam int CNT_W = 16;

   logic             refclk      = 1'b0;
   logic             reset_n     = 1'b1;
   logic             enable      = 1'b0;
   logic             meas_tog    = 1'b0;
   logic             pll_lock_in = 1'b0;
   logic             pll_reset;
   logic             locked;
   logic [CNT_W-1:0] freq_count;
   logic             count_valid;
   logic [7:0]       relock_count;

   int n_checks = 0;
   int n_pass   = 0;

   // Generator control: 0 = quiet, 1 = period-5 wave, 2 = burst on request.
   int mode   = 0;
   int req_id = 0;
   int req_n  = 0;
   int g_seen = 0;
   int g_rem  = 0;
   int g_ph   = 0;
   int g_pp   = 0;

   pll_lock_monitor #(
      .REF_WINDOW    (100),
      .EXP_COUNT     (20),
      .TOL           (1),
      .LOCK_WINDOWS  (3),
      .MAX_MISS      (2),
      .RST_CYCLES    (8),
      .SETTLE_CYCLES (20),
      .CNT_W         (CNT_W)
   ) dut (
      .refclk       (refclk),
      .reset_n      (reset_n),
      .enable       (enable),
      .meas_tog     (meas_tog),
      .pll_lock_in  (pll_lock_in),
      .pll_reset    (pll_reset),
      .locked       (locked),
      .freq_count   (freq_count),
      .count_valid  (count_valid),
      .relock_count (relock_count)
   );

   always #5 refclk = ~refclk;

   // meas_tog generator, updated on the falling edge.
   initial begin
      forever begin
         @(negedge refclk);
         if (mode == 1) begin
            meas_tog = (g_pp < 2);
            g_pp     = (g_pp == 4) ? 0 : g_pp + 1;
         end else if (mode == 2) begin
            if (req_id != g_seen) begin
               g_seen = req_id;
               g_rem  = req_n;
               g_ph   = 0;
            end
            if (g_rem > 0) begin
               meas_tog = (g_ph == 0);
               g_ph     = g_ph + 1;
               if (g_ph == 3) begin
                  g_ph  = 0;
                  g_rem = g_rem - 1;
               end
            end else begin
               meas_tog = 1'b0;
            end
         end else begin
            meas_tog = 1'b0;
         end
      end
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge refclk);
      #1;
   endtask

   task automatic wait_cv(input string tag);
      int i;
      i = 0;
      do begin
         tick();
         i++;
      end while ((count_valid !== 1'b1) && (i < 400));
      if (count_valid !== 1'b1) check_val({tag, "_cv_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic burst(input int n);
      req_n  = n;
      req_id = req_id + 1;
   endtask

   task automatic check_window(input string tag, input int fexp, input logic lexp);
      wait_cv(tag);
      check_val({tag, "_freq"}, 32'(freq_count), 32'(fexp));
      check_val({tag, "_locked"}, 32'(locked), 32'(lexp));
   endtask

   initial begin
      int nhigh;
      int ncv;
      mode        = 1;
      pll_lock_in = 1'b1;
      #2 reset_n  = 1'b0;
      repeat (3) tick();
      check_val("rst_pll_reset", 32'(pll_reset), 32'd1);
      check_val("rst_locked", 32'(locked), 32'd0);
      check_val("rst_freq", 32'(freq_count), 32'd0);
      check_val("rst_cv", 32'(count_valid), 32'd0);
      check_val("rst_relock", 32'(relock_count), 32'd0);
      @(negedge refclk);
      reset_n = 1'b1;
      tick();
      tick();
      check_val("idle_pll_reset", 32'(pll_reset), 32'd1);

      // 1. Nominal lock
      enable = 1'b1;
      nhigh  = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (pll_reset !== 1'b1) break;
         nhigh++;
      end
      check_val("t1_rst_cycles", 32'(nhigh), 32'd8);
      check_window("t1_w1", 20, 1'b0);
      check_window("t1_w2", 20, 1'b0);
      check_window("t1_w3", 20, 1'b1);
      check_val("t1_relock", 32'(relock_count), 32'd0);

      // 4. Lock drop mid-window while LOCKED
      check_window("t4_sync", 20, 1'b1);
      repeat (40) tick();
      pll_lock_in = 1'b0;
      mode        = 2;
      tick();
      tick();
      check_val("t4_locked_pre", 32'(locked), 32'd1);
      tick();
      check_val("t4_locked_drop", 32'(locked), 32'd0);
      check_val("t4_pll_reset", 32'(pll_reset), 32'd1);
      check_val("t4_relock", 32'(relock_count), 32'd1);
      ncv = 0;
      repeat (60) begin
         tick();
         if (count_valid === 1'b1) ncv++;
      end
      check_val("t4_no_cv", 32'(ncv), 32'd0);
      pll_lock_in = 1'b1;

      // 2. Tolerance edges
      check_window("t2_w0", 0, 1'b0);
      burst(19);
      check_window("t2_19", 19, 1'b0);
      burst(21);
      check_window("t2_21", 21, 1'b0);
      burst(22);
      check_window("t2_22", 22, 1'b0);
      check_val("t2_pll_reset", 32'(pll_reset), 32'd0);

      // 3. Persistent frequency error
      burst(30);
      check_window("t3_30a", 30, 1'b0);
      check_val("t3_pll_reset_a", 32'(pll_reset), 32'd1);
      check_val("t3_relock_a", 32'(relock_count), 32'd2);
      check_window("t3_zero", 0, 1'b0);
      burst(30);
      check_window("t3_30b", 30, 1'b0);
      check_val("t3_pll_reset_b", 32'(pll_reset), 32'd1);
      check_val("t3_relock_b", 32'(relock_count), 32'd3);
      mode = 1;
      check_window("t3_fix1", 20, 1'b0);
      check_window("t3_fix2", 20, 1'b0);
      check_window("t3_fix3", 20, 1'b1);
      check_val("t3_relock_c", 32'(relock_count), 32'd3);

      // 5. enable low while LOCKED, then high again
      enable = 1'b0;
      tick();
      check_val("t5_pll_reset", 32'(pll_reset), 32'd1);
      check_val("t5_locked", 32'(locked), 32'd0);
      check_val("t5_relock", 32'(relock_count), 32'd3);
      tick();
      enable = 1'b1;
      check_window("t5_w1", 20, 1'b0);
      check_window("t5_w2", 20, 1'b0);
      check_window("t5_w3", 20, 1'b1);
      check_val("t5_relock_b", 32'(relock_count), 32'd3);

      // Bad window while LOCKED, then async reset mid-MEASURE
      mode = 2;
      wait_cv("t6_bad");
      check_val("t6_bad_locked", 32'(locked), 32'd0);
      check_val("t6_bad_pll_reset", 32'(pll_reset), 32'd1);
      check_val("t6_bad_relock", 32'(relock_count), 32'd4);
      check_window("t6_meas", 0, 1'b0);
      repeat (40) tick();
      @(negedge refclk);
      #1 reset_n = 1'b0;
      #1;
      check_val("t6_pll_reset", 32'(pll_reset), 32'd1);
      check_val("t6_locked", 32'(locked), 32'd0);
      check_val("t6_freq", 32'(freq_count), 32'd0);
      check_val("t6_cv", 32'(count_valid), 32'd0);
      check_val("t6_relock", 32'(relock_count), 32'd0);
      @(negedge refclk);
      reset_n = 1'b1;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
